// File: rtl/md_unit.sv
// md_unit: multiply/divide unit for the EX stage.
// It runs MULT/MULTU/DIV/DIVU as timed multi-cycle operations and holds the
// HI/LO registers. It also serves MTHI/MTLO writes and MFHI/MFLO reads.
// The result is computed at the start edge and held in shadow registers. The
// shadow is copied into HI/LO on the last busy cycle.
// Optional feature: define MD_MADD_EN to enable md_op 7 (signed multiply-
// accumulate into {HI,LO}). When it is undefined, op 7 is a no-op and no
// accumulator adder is built.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  md_op,
  input  logic        start,
  input  logic        rd_hi,
  output logic        busy,
  output logic [31:0] md_out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
`ifdef MD_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'd7;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_p0;
  logic [CNT_W-1:0]   cnt_p0;
  logic               cmt_p0;
  logic        [31:0] hi_reg;
  logic        [31:0] lo_reg;
  logic        [31:0] shd_hi_p0;
  logic        [31:0] shd_lo_p0;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [63:0] quo_s;
  logic        [63:0] quo_u;
`ifdef MD_MADD_EN
  logic        [63:0] acc_sum;
`endif

  // Signed 32x32 -> 64 product, operands sign-extended first.
  function automatic logic signed [63:0] mul_s(input logic signed [31:0] a,
                                               input logic signed [31:0] b);
    logic signed [63:0] ae;
    logic signed [63:0] be;
    ae = 64'(a);
    be = 64'(b);
    return ae * be;
  endfunction

  // Unsigned 32x32 -> 64 product.
  function automatic logic [63:0] mul_u(input logic [31:0] a, input logic [31:0] b);
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Signed divide returning {remainder, quotient}. The quotient truncates
  // toward zero. A zero divisor gives a don't-care value, because that result
  // is never committed. The overflow case -2^31 / -1 saturates to -2^31 with a
  // remainder of zero.
  function automatic logic [63:0] div_s(input logic signed [31:0] n,
                                        input logic signed [31:0] d);
    logic signed [31:0] q;
    logic signed [31:0] r;
    q = '0;
    r = '0;
    if (d == 32'sd0) begin
      q = '0;
    end else if (n == 32'sh8000_0000 && d == -32'sd1) begin
      q = n;
    end else begin
      q = n / d;
      r = n % d;
    end
    return {r, q};
  endfunction

  // Unsigned divide returning {remainder, quotient}. A zero divisor gives a
  // don't-care value.
  function automatic logic [63:0] div_u(input logic [31:0] n, input logic [31:0] d);
    logic [31:0] q;
    logic [31:0] r;
    q = '0;
    r = '0;
    if (d != 32'd0) begin
      q = n / d;
      r = n % d;
    end
    return {r, q};
  endfunction

  // Candidate results from the current operands, captured only on a start edge.
  always_comb begin
    prod_s = mul_s($signed(A), $signed(B));
    prod_u = mul_u(A, B);
    quo_s  = div_s($signed(A), $signed(B));
    quo_u  = div_u(A, B);
`ifdef MD_MADD_EN
    acc_sum = {hi_reg, lo_reg} + 64'(prod_s);
`endif
  end

  // Control FSM with its counter, shadow capture, and HI/LO commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p0  <= IDLE;
      cnt_p0    <= '0;
      cmt_p0    <= 1'b0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      shd_hi_p0 <= '0;
      shd_lo_p0 <= '0;
    end else begin
      case (state_p0)
        IDLE: begin
          if (start) begin
            case (md_op)
              OP_MULT: begin
                {shd_hi_p0, shd_lo_p0} <= prod_s;
                cnt_p0   <= CNT_W'(MULT_CYCLES);
                cmt_p0   <= 1'b1;
                state_p0 <= RUN;
              end
              OP_MULTU: begin
                {shd_hi_p0, shd_lo_p0} <= prod_u;
                cnt_p0   <= CNT_W'(MULT_CYCLES);
                cmt_p0   <= 1'b1;
                state_p0 <= RUN;
              end
              OP_DIV: begin
                {shd_hi_p0, shd_lo_p0} <= quo_s;
                cnt_p0   <= CNT_W'(DIV_CYCLES);
                cmt_p0   <= (B != 32'd0);
                state_p0 <= RUN;
              end
              OP_DIVU: begin
                {shd_hi_p0, shd_lo_p0} <= quo_u;
                cnt_p0   <= CNT_W'(DIV_CYCLES);
                cmt_p0   <= (B != 32'd0);
                state_p0 <= RUN;
              end
              OP_MTHI: hi_reg <= A;
              OP_MTLO: lo_reg <= A;
`ifdef MD_MADD_EN
              OP_MADD: begin
                {shd_hi_p0, shd_lo_p0} <= acc_sum;
                cnt_p0   <= CNT_W'(MULT_CYCLES);
                cmt_p0   <= 1'b1;
                state_p0 <= RUN;
              end
`endif
              default: ;
            endcase
          end
        end
        RUN: begin
          cnt_p0 <= cnt_p0 - CNT_W'(1);
          if (cnt_p0 == CNT_W'(1)) begin
            state_p0 <= IDLE;
            if (cmt_p0) begin
              hi_reg <= shd_hi_p0;
              lo_reg <= shd_lo_p0;
            end
          end
        end
        default: state_p0 <= IDLE;
      endcase
    end
  end

  // Busy is a decode of the FSM state. The read port only sees committed HI/LO.
  always_comb begin
    busy   = (state_p0 == RUN);
    md_out = rd_hi ? hi_reg : lo_reg;
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed and randomized bench for md_unit.
// A behavioural model of HI/LO is built from 64-bit integer arithmetic.
module tb_md_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;
`ifdef MD_MADD_EN
  localparam bit MADD_ON = 1'b1;
`else
  localparam bit MADD_ON = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  md_op;
  logic        start;
  logic        rd_hi;
  logic        busy;
  logic [31:0] md_out;

  int          total;
  int          bad;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk    (clk),
    .reset  (reset),
    .A      (A),
    .B      (B),
    .md_op  (md_op),
    .start  (start),
    .rd_hi  (rd_hi),
    .busy   (busy),
    .md_out (md_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference: new {HI,LO} from plain 64-bit integer arithmetic.
  function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] hl);
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] ua;
    logic [63:0] ub;
    logic [63:0] res;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    res = hl;
    case (op)
      3'd1: res = sa * sb;
      3'd2: res = ua * ub;
      3'd3: if (b != 32'd0) begin
        q   = sa / sb;
        r   = sa % sb;
        res = {r[31:0], q[31:0]};
      end
      3'd4: if (b != 32'd0) res = {32'(ua % ub), 32'(ua / ub)};
      3'd5: res = {a, hl[31:0]};
      3'd6: res = {hl[63:32], a};
      3'd7: if (MADD_ON) res = hl + 64'(sa * sb);
      default: res = hl;
    endcase
    return res;
  endfunction

  function automatic int ref_cycles(input logic [2:0] op);
    if (op == 3'd1 || op == 3'd2) return MULT_N;
    if (op == 3'd3 || op == 3'd4) return DIV_N;
    if (op == 3'd7 && MADD_ON) return MULT_N;
    return 0;
  endfunction

  task automatic read_hilo(output logic [31:0] hv, output logic [31:0] lv);
    rd_hi = 1'b1;
    #1 hv = md_out;
    rd_hi = 1'b0;
    #1 lv = md_out;
  endtask

  // Issue one op, check the busy length, check that LO holds while busy, then check the committed HI/LO.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b);
    logic [63:0] nxt;
    logic [31:0] hv;
    logic [31:0] lv;
    int          exp_n;
    int          n;
    nxt   = ref_op(op, a, b, {m_hi, m_lo});
    exp_n = ref_cycles(op);
    @(negedge clk);
    A = a; B = b; md_op = op; start = 1'b1; rd_hi = 1'b0;
    @(negedge clk);
    start = 1'b0; md_op = 3'd0; A = $urandom; B = $urandom;
    n = 0;
    while (busy === 1'b1 && n < 64) begin
      chk({tag, "_hold"}, md_out, m_lo);
      n++;
      @(negedge clk);
    end
    chk({tag, "_cyc"}, 32'(n), 32'(exp_n));
    m_hi = nxt[63:32];
    m_lo = nxt[31:0];
    read_hilo(hv, lv);
    chk({tag, "_hi"}, hv, m_hi);
    chk({tag, "_lo"}, lv, m_lo);
  endtask

  initial begin
    logic [31:0] hv;
    logic [31:0] lv;
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int          n;
    total = 0; bad = 0;
    m_hi = '0; m_lo = '0;
    A = '0; B = '0; md_op = '0; start = 1'b0; rd_hi = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    read_hilo(hv, lv);
    chk("rst_hi", hv, 32'd0);
    chk("rst_lo", lv, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op("mult", 3'd1, 32'hFFFF_FFFE, 32'h0000_0003);
    chk("mult_hi_k", m_hi, 32'hFFFF_FFFF);
    chk("mult_lo_k", m_lo, 32'hFFFF_FFFA);
    run_op("divu", 3'd4, 32'd100, 32'd7);
    chk("divu_k", {m_hi[15:0], m_lo[15:0]}, {16'd2, 16'd14});
    run_op("div", 3'd3, 32'hFFFF_FFF9, 32'd2);
    chk("div_lo_k", m_lo, 32'hFFFF_FFFD);
    chk("div_hi_k", m_hi, 32'hFFFF_FFFF);

    run_op("mthi", 3'd5, 32'h11, 32'h0);
    run_op("mtlo", 3'd6, 32'h22, 32'h0);
    run_op("div0", 3'd3, 32'd55, 32'd0);
    chk("div0_k", {m_hi[15:0], m_lo[15:0]}, {16'h11, 16'h22});
    run_op("mtlo2", 3'd6, 32'h1234, 32'h0);
    chk("mtlo2_hi_k", m_hi, 32'h11);

    // A second start while busy must be ignored. The mult still commits on schedule.
    @(negedge clk);
    A = 32'd7; B = 32'd6; md_op = 3'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 64) begin
      if (n == 1) begin
        md_op = 3'd3; A = 32'd100; B = 32'd5; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      n++;
      @(negedge clk);
    end
    start = 1'b0; md_op = 3'd0;
    chk("coll_cyc", 32'(n), 32'(MULT_N));
    m_hi = 32'd0; m_lo = 32'd42;
    read_hilo(hv, lv);
    chk("coll_hi", hv, 32'd0);
    chk("coll_lo", lv, 32'd42);
    @(negedge clk);
    chk("coll_idle", 32'(busy), 32'd0);

    run_op("nop", 3'd0, 32'hDEAD_BEEF, 32'h1);

    run_op("madd_ph", 3'd5, 32'h0, 32'h0);
    run_op("madd_pl", 3'd6, 32'hFFFF_FFFF, 32'h0);
    run_op("madd", 3'd7, 32'd1, 32'd1);
    chk("madd_hi_k", m_hi, MADD_ON ? 32'd1 : 32'd0);
    chk("madd_lo_k", m_lo, MADD_ON ? 32'd0 : 32'hFFFF_FFFF);

    run_op("ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("ovf_k", m_lo ^ m_hi, 32'h8000_0000);

    for (int i = 0; i < 30; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 5) == 0) rb = 32'd0;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
      if ($urandom_range(0, 3) == 0) ra = -ra;
      run_op("rnd", rop, ra, rb);
    end

    // Reset in the middle of a div: busy drops at once and nothing commits later.
    run_op("pre_rst", 3'd5, 32'hA5A5_0001, 32'h0);
    @(negedge clk);
    A = 32'd1000; B = 32'd3; md_op = 3'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0; md_op = 3'd0;
    repeat (3) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    read_hilo(hv, lv);
    chk("arst_hi", hv, 32'd0);
    chk("arst_lo", lv, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    n = 0;
    for (int i = 0; i < DIV_N + 2; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) n++;
    end
    chk("arst_nobusy", 32'(n), 32'd0);
    read_hilo(hv, lv);
    chk("arst_hi_late", hv, 32'd0);
    chk("arst_lo_late", lv, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
